// File: rtl/bt_cmd_pkg.sv
// Shared constants and state encodings for the Bluetooth command receiver.
// Command byte values match what the phone app sends to the player.
package bt_cmd_pkg;

    localparam logic [7:0] CMD_NEXT  = 8'h4E;
    localparam logic [7:0] CMD_PREV  = 8'h50;
    localparam logic [7:0] CMD_VUP   = 8'h2B;
    localparam logic [7:0] CMD_VDN   = 8'h2D;
    localparam logic [7:0] CMD_VSET  = 8'h56;
    localparam logic [7:0] CMD_SONG0 = 8'h30;
    localparam logic [7:0] ATT_MAX   = 8'hFE;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
    typedef enum logic {C_CMD, C_ARG} cmd_state_e;

    // ASCII '0'..'7' share the upper five bits 5'b00110.
    function automatic logic isSongCmd(input logic [7:0] b);
        return b[7:3] == CMD_SONG0[7:3];
    endfunction

endpackage

// File: rtl/bt_cmd_rx_if.sv
// Signal bundle between the Bluetooth UART line and the control selector.
// The slave side is the receiver itself; the master side drives RXD.
interface bt_cmd_rx_if;
    logic        RXD;
    logic [2:0]  current;
    logic [15:0] volume;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        frame_err;
    logic        cmd_ack;

    modport master (output RXD, input current, volume, rx_byte, rx_valid, frame_err, cmd_ack);
    modport slave  (input RXD, output current, volume, rx_byte, rx_valid, frame_err, cmd_ack);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchroniser, bit-centre timer and framing FSM.
// Emits a one-cycle rx_valid or frame_err pulse the cycle after the stop-bit sample.
module uart_rx_byte
    import bt_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       frame_err_o
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic             rxMeta_q, rxSync_q, rxPrev_q;
    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             fallEdge;

    // A stuck-low line after a bad stop bit never re-triggers: a start needs high-then-low.
    assign fallEdge = rxPrev_q & ~rxSync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
            state_q  <= U_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rxMeta_q <= rxd_i;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            U_IDLE: begin
                if (fallEdge) begin
                    state_d = U_START;
                    cnt_d   = '0;
                end
            end
            U_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxSync_q ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            U_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rxSync_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = U_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            U_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = U_IDLE;
                    if (rxSync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

    assign rx_byte_o   = byte_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/bt_cmd_rx.sv
// Bluetooth command receiver: decodes song/volume commands from the UART byte stream
// and holds the song index and VS1003 volume word for the control selector.
module bt_cmd_rx
    import bt_cmd_pkg::*;
#(
    parameter int         CLK_HZ          = 100_000_000,
    parameter int         BAUD            = 9600,
    parameter logic [7:0] VOL_STEP        = 8'h10,
    parameter logic [7:0] VOL_RESET       = 8'h20,
    parameter int         ARG_TIMEOUT_CYC = 100_000_000
) (
    input  logic      clk,
    input  logic      rst,
    bt_cmd_rx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TO_W         = $clog2(ARG_TIMEOUT_CYC + 1);

    logic [7:0] rxByte;
    logic       rxValid, frameErr;

    cmd_state_e      cmdState_q, cmdState_d;
    logic [2:0]      current_q, current_d;
    logic [7:0]      att_q, att_d;
    logic            ack_q, ack_d;
    logic [TO_W-1:0] toCnt_q, toCnt_d;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
        .clk        (clk),
        .rst        (rst),
        .rxd_i      (bus.RXD),
        .rx_byte_o  (rxByte),
        .rx_valid_o (rxValid),
        .frame_err_o(frameErr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmdState_q <= C_CMD;
            current_q  <= '0;
            att_q      <= VOL_RESET;
            ack_q      <= 1'b0;
            toCnt_q    <= '0;
        end else begin
            cmdState_q <= cmdState_d;
            current_q  <= current_d;
            att_q      <= att_d;
            ack_q      <= ack_d;
            toCnt_q    <= toCnt_d;
        end
    end

    // Saturated +/- still acknowledge so the app sees its key press was taken.
    always_comb begin
        cmdState_d = cmdState_q;
        current_d  = current_q;
        att_d      = att_q;
        ack_d      = 1'b0;
        toCnt_d    = toCnt_q;
        case (cmdState_q)
            C_CMD: begin
                if (rxValid) begin
                    if (isSongCmd(rxByte)) begin
                        current_d = rxByte[2:0];
                        ack_d     = 1'b1;
                    end else if (rxByte == CMD_NEXT) begin
                        current_d = current_q + 3'd1;
                        ack_d     = 1'b1;
                    end else if (rxByte == CMD_PREV) begin
                        current_d = current_q - 3'd1;
                        ack_d     = 1'b1;
                    end else if (rxByte == CMD_VUP) begin
                        att_d = (att_q < VOL_STEP) ? 8'h00 : att_q - VOL_STEP;
                        ack_d = 1'b1;
                    end else if (rxByte == CMD_VDN) begin
                        att_d = (att_q > ATT_MAX - VOL_STEP) ? ATT_MAX : att_q + VOL_STEP;
                        ack_d = 1'b1;
                    end else if (rxByte == CMD_VSET) begin
                        cmdState_d = C_ARG;
                        toCnt_d    = '0;
                    end
                end
            end
            C_ARG: begin
                if (rxValid) begin
                    att_d      = (rxByte > ATT_MAX) ? ATT_MAX : rxByte;
                    ack_d      = 1'b1;
                    toCnt_d    = '0;
                    cmdState_d = C_CMD;
                end else if (frameErr || toCnt_q == TO_W'(ARG_TIMEOUT_CYC - 1)) begin
                    cmdState_d = C_CMD;
                end else begin
                    toCnt_d = toCnt_q + TO_W'(1);
                end
            end
            default: cmdState_d = C_CMD;
        endcase
    end

    assign bus.current   = current_q;
    assign bus.volume    = {att_q, att_q};
    assign bus.rx_byte   = rxByte;
    assign bus.rx_valid  = rxValid;
    assign bus.frame_err = frameErr;
    assign bus.cmd_ack   = ack_q;

endmodule

// File: tb/tb_bt_cmd_rx.sv
// Directed bench for bt_cmd_rx: a table of command bytes with hand-computed results,
// then hand-written sequences for timeout, framing error, glitch, back-to-back and reset.
module tb_bt_cmd_rx;
    import bt_cmd_pkg::*;

    localparam int CLK_HZ  = 160;
    localparam int BAUD    = 10;
    localparam int CPB     = CLK_HZ / BAUD;
    localparam int TIMEOUT = 400;

    typedef struct {
        logic [7:0]  byteIn;
        logic [2:0]  expCurrent;
        logic [15:0] expVolume;
        int          expAck;
    } vector_t;

    logic clk = 1'b0;
    logic rst;
    bt_cmd_rx_if bus();

    bt_cmd_rx #(
        .CLK_HZ         (CLK_HZ),
        .BAUD           (BAUD),
        .VOL_STEP       (8'h10),
        .VOL_RESET      (8'h20),
        .ARG_TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ackCount = 0;
    int validCount = 0;
    int errCount = 0;
    int ack0, val0, err0;
    vector_t vecs[16];

    // Pulse counters let each step check exactly how many pulses it produced.
    always @(posedge clk) begin
        if (bus.cmd_ack)   ackCount   <= ackCount + 1;
        if (bus.rx_valid)  validCount <= validCount + 1;
        if (bus.frame_err) errCount   <= errCount + 1;
    end

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        bus.RXD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RXD = data[i];
            repeat (CPB) @(negedge clk);
        end
        bus.RXD = stopBit;
        repeat (CPB) @(negedge clk);
        bus.RXD = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic snapshot();
        ack0 = ackCount;
        val0 = validCount;
        err0 = errCount;
    endtask

    initial begin
        vecs[0]  = '{8'h33, 3'd3, 16'h2020, 1};
        vecs[1]  = '{8'h37, 3'd7, 16'h2020, 1};
        vecs[2]  = '{8'h4E, 3'd0, 16'h2020, 1};
        vecs[3]  = '{8'h50, 3'd7, 16'h2020, 1};
        vecs[4]  = '{8'h2B, 3'd7, 16'h1010, 1};
        vecs[5]  = '{8'h2B, 3'd7, 16'h0000, 1};
        vecs[6]  = '{8'h2B, 3'd7, 16'h0000, 1};
        vecs[7]  = '{8'h56, 3'd7, 16'h0000, 0};
        vecs[8]  = '{8'hFF, 3'd7, 16'hFEFE, 1};
        vecs[9]  = '{8'h2D, 3'd7, 16'hFEFE, 1};
        vecs[10] = '{8'h56, 3'd7, 16'hFEFE, 0};
        vecs[11] = '{8'h4E, 3'd7, 16'h4E4E, 1};
        vecs[12] = '{8'h78, 3'd7, 16'h4E4E, 0};
        vecs[13] = '{8'h2D, 3'd7, 16'h5E5E, 1};
        vecs[14] = '{8'h50, 3'd6, 16'h5E5E, 1};
        vecs[15] = '{8'h30, 3'd0, 16'h5E5E, 1};

        bus.RXD = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset current", 32'(bus.current), 32'd0);
        checkOutput("reset volume", 32'(bus.volume), 32'h2020);
        checkOutput("reset rx_byte", 32'(bus.rx_byte), 32'h00);
        checkOutput("reset pulses", {29'd0, bus.rx_valid, bus.frame_err, bus.cmd_ack}, 32'd0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        for (int v = 0; v < 16; v++) begin
            snapshot();
            applyStimulus(vecs[v].byteIn, 1'b1);
            repeat (2) @(negedge clk);
            checkOutput($sformatf("vec%0d current", v), 32'(bus.current), 32'(vecs[v].expCurrent));
            checkOutput($sformatf("vec%0d volume", v), 32'(bus.volume), 32'(vecs[v].expVolume));
            checkOutput($sformatf("vec%0d rx_byte", v), 32'(bus.rx_byte), 32'(vecs[v].byteIn));
            checkOutput($sformatf("vec%0d rx_valid count", v), 32'(validCount - val0), 32'd1);
            checkOutput($sformatf("vec%0d cmd_ack count", v), 32'(ackCount - ack0), 32'(vecs[v].expAck));
        end

        // Argument timeout: '5' after the window must be a song command, not an argument.
        snapshot();
        applyStimulus(8'h56, 1'b1);
        repeat (TIMEOUT + 10) @(negedge clk);
        applyStimulus(8'h35, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("timeout current", 32'(bus.current), 32'd5);
        checkOutput("timeout volume", 32'(bus.volume), 32'h5E5E);
        checkOutput("timeout ack count", 32'(ackCount - ack0), 32'd1);

        // Argument arriving well inside the window is still taken.
        snapshot();
        applyStimulus(8'h56, 1'b1);
        repeat (100) @(negedge clk);
        applyStimulus(8'h40, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("late arg volume", 32'(bus.volume), 32'h4040);
        checkOutput("late arg current", 32'(bus.current), 32'd5);

        // Bad stop bit: error pulse only, last good byte held.
        snapshot();
        applyStimulus(8'h31, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checkOutput("ferr frame_err count", 32'(errCount - err0), 32'd1);
        checkOutput("ferr rx_valid count", 32'(validCount - val0), 32'd0);
        checkOutput("ferr current", 32'(bus.current), 32'd5);
        checkOutput("ferr rx_byte", 32'(bus.rx_byte), 32'h40);

        // Framing error while waiting for an argument drops back to command mode.
        snapshot();
        applyStimulus(8'h56, 1'b1);
        applyStimulus(8'h11, 1'b0);
        repeat (CPB) @(negedge clk);
        applyStimulus(8'h32, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("arg ferr current", 32'(bus.current), 32'd2);
        checkOutput("arg ferr volume", 32'(bus.volume), 32'h4040);
        checkOutput("arg ferr ack count", 32'(ackCount - ack0), 32'd1);

        // Quarter-bit glitch on idle line.
        snapshot();
        bus.RXD = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        bus.RXD = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("glitch rx_valid count", 32'(validCount - val0), 32'd0);
        checkOutput("glitch frame_err count", 32'(errCount - err0), 32'd0);
        applyStimulus(8'h34, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("post glitch current", 32'(bus.current), 32'd4);

        // Back-to-back frames with no idle gap.
        snapshot();
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h4E, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("b2b rx_valid count", 32'(validCount - val0), 32'd2);
        checkOutput("b2b ack count", 32'(ackCount - ack0), 32'd2);
        checkOutput("b2b current", 32'(bus.current), 32'd2);

        // Asynchronous reset in the middle of '2'.
        bus.RXD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.RXD = (i == 1);
            repeat (CPB) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst current", 32'(bus.current), 32'd0);
        checkOutput("async rst volume", 32'(bus.volume), 32'h2020);
        checkOutput("async rst rx_byte", 32'(bus.rx_byte), 32'h00);
        bus.RXD = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        snapshot();
        applyStimulus(8'h36, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("post rst current", 32'(bus.current), 32'd6);
        checkOutput("post rst volume", 32'(bus.volume), 32'h2020);
        checkOutput("post rst rx_valid count", 32'(validCount - val0), 32'd1);
        checkOutput("post rst rx_byte", 32'(bus.rx_byte), 32'h36);
        checkOutput("post rst frame_err count", 32'(errCount - err0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bt_cmd_rx.md
# bt_cmd_rx

Bluetooth command receiver: deserialises the 8N1 UART stream arriving on `RXD` from the Bluetooth module, decodes single-byte and two-byte player commands, and holds the resulting song index and VS1003 volume word. It sits directly upstream of the control selector, which forwards `current`/`volume` to the MP3 decoder driver when Bluetooth control is chosen.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency
- `BAUD`, 9600, UART bit rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division, 10416)
- `VOL_STEP`, 8'h10, attenuation change per `+`/`-`
- `VOL_RESET`, 8'h20, attenuation after reset
- `ARG_TIMEOUT_CYC`, 100_000_000, max wait for the argument byte of `V`

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `RXD`  in  1  UART line from Bluetooth module, idle high, asynchronous to `clk`
- `current`  out  3  selected song index
- `volume`  out  16  VS1003 SCI_VOL word, `{att, att}`
- `rx_byte`  out  8  last correctly framed byte
- `rx_valid`  out  1  one-cycle pulse, `rx_byte` updated
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low
- `cmd_ack`  out  1  one-cycle pulse, a command changed or re-applied `current`/`volume`

## Operation
- Reset values: `current`=0, `volume`={VOL_RESET,VOL_RESET}=16'h2020, `rx_byte`=0, all pulses 0, both FSMs idle.
- `RXD` passes a 2-flop synchroniser (reset to 1) before any use.
- UART FSM: IDLE -> START on synchronised falling edge; START waits CLKS_PER_BIT/2, if line high -> IDLE (glitch, no pulse), else DATA; DATA samples 8 bits LSB-first, one CLKS_PER_BIT apart at bit centres; STOP samples after one more CLKS_PER_BIT: high -> `rx_valid`, low -> `frame_err`, byte discarded; then IDLE (new start edge accepted only after line seen high).
- Command FSM (consumes `rx_valid` only):
  - `'0'`..`'7'` (8'h30..8'h37): `current` = byte[2:0].
  - `'N'` (8'h4E): `current` + 1, 7 wraps to 0. `'P'` (8'h50): `current` - 1, 0 wraps to 7.
  - `'+'` (8'h2B): att = att - VOL_STEP, saturate at 8'h00 (louder).
  - `'-'` (8'h2D): att = att + VOL_STEP, saturate at 8'hFE.
  - `'V'` (8'h56): enter ARG; next valid byte sets att = min(byte, 8'hFE); return to CMD.
  - Any other byte in CMD: ignored, no `cmd_ack`.
- ARG: `frame_err` or ARG_TIMEOUT_CYC cycles without `rx_valid` -> CMD, no change, no ack. Any byte value (including command codes) is treated as the argument.
- `cmd_ack` also fires on saturated no-op `+`/`-`.

## Timing
- `rx_valid`/`frame_err` assert the cycle after the stop-bit sample; `rx_byte` valid in that same cycle and held until next good byte.
- `current`/`volume` and `cmd_ack` update one cycle after `rx_valid`.
- Edge-to-sample latency: 2 sync cycles + CLKS_PER_BIT/2 to start-bit centre.
- Timeout counter starts the cycle ARG is entered, clears on every `rx_valid`.
- Asynchronous `rst` mid-frame: all state to reset values immediately; partial byte lost; after release, receiver resumes only on a fresh falling edge.
- Back-to-back frames (stop bit immediately followed by start) must be received without loss.

## Structure
- Package `bt_cmd_pkg`: command byte constants (`CMD_NEXT`, `CMD_PREV`, `CMD_VUP`, `CMD_VDN`, `CMD_VSET`, `CMD_SONG0`), `ATT_MAX`=8'hFE, UART and command state enums.
- Sub-module `uart_rx_byte` (synchroniser, bit timer, UART FSM; outputs `rx_byte`, `rx_valid`, `frame_err`); `bt_cmd_rx` instantiates it and holds the command FSM and output registers.

## Test plan
- Reset, send `'3'` -> `current`=3, `volume`=16'h2020, one `cmd_ack`.
- `current`=7, send `'N'` -> 0; then `'P'` -> 7.
- Reset, send `'+'` x3 -> att 8'h10, 8'h00, 8'h00 (`volume`=16'h0000), three acks; then `'V'`,8'hFF -> `volume`=16'hFEFE.
- Send `'V'`, wait ARG_TIMEOUT_CYC+10 cycles, send `'5'` -> `current`=5, `volume` unchanged.
- Frame with stop bit low -> `frame_err` pulse, no `rx_valid`, outputs unchanged; 1/4-bit low glitch on idle line -> no pulses.
- Assert `rst` mid-byte of `'2'`, release, send `'6'` -> `current`=6 only, no spurious byte.
